// File: rtl/bus_master_if.sv
// Request/response and bus-strobe bundle for bus_master.
// With BUS_MASTER_ALIGN_CHECK_EN defined the bundle also carries err.
interface bus_master_if;
  logic        req;
  logic        we;
  logic        dword;
  logic [19:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [19:0] bus_addr;
  logic        read;
  logic        write;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
  logic        err;

  modport master (
    input  req, we, dword, addr, wdata,
    output busy, done, rdata, bus_addr, read, write, err
  );
  modport slave (
    output req, we, dword, addr, wdata,
    input  busy, done, rdata, bus_addr, read, write, err
  );
`else
  modport master (
    input  req, we, dword, addr, wdata,
    output busy, done, rdata, bus_addr, read, write
  );
  modport slave (
    output req, we, dword, addr, wdata,
    input  busy, done, rdata, bus_addr, read, write
  );
`endif
endinterface

// File: rtl/bus_master.sv
// CPU-side initiator: runs 16/32-bit requests as one or two external bus cycles.
// Optional BUS_MASTER_ALIGN_CHECK_EN rejects odd-address double-word requests with err.
module bus_master #(
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         reset,
  bus_master_if.master bif,
  inout  wire  [15:0]  bus_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        dword_q, dword_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [19:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    dword_d     = dword_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    read_d      = read_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bif.req) begin
          we_d    = bif.we;
          dword_d = bif.dword;
          addr_d  = bif.addr;
          wdata_d = bif.wdata;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
          // Misaligned double word: skip the bus entirely and report via err.
          if (bif.dword && bif.addr[0]) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else
`endif
          begin
            state_d     = LO;
            bus_addr_d  = bif.addr;
            read_d      = !bif.we;
            write_d     = bif.we;
            bus_wdata_d = bif.wdata[15:0];
            cnt_d       = WAIT_INIT;
          end
        end
      end

      LO: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            rdata_d[15:0] = bus_data;
            if (!dword_q) rdata_d[31:16] = 16'h0000;
          end
          if (dword_q) begin
            state_d     = HI;
            bus_addr_d  = addr_q + 20'd1;
            bus_wdata_d = wdata_q[31:16];
            cnt_d       = WAIT_INIT;
          end else begin
            state_d = FIN;
            read_d  = 1'b0;
            write_d = 1'b0;
          end
        end
      end

      HI: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) rdata_d[31:16] = bus_data;
          state_d = FIN;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
        err_d   = 1'b0;
`endif
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      dword_q     <= 1'b0;
      addr_q      <= 20'd0;
      wdata_q     <= 32'd0;
      bus_addr_q  <= 20'd0;
      bus_wdata_q <= 16'd0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      rdata_q     <= 32'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      dword_q     <= dword_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus_data     = write_q ? bus_wdata_q : 16'hzzzz;
  assign bif.busy     = busy_q;
  assign bif.done     = done_q;
  assign bif.rdata    = rdata_q;
  assign bif.bus_addr = bus_addr_q;
  assign bif.read     = read_q;
  assign bif.write    = write_q;
`ifdef BUS_MASTER_ALIGN_CHECK_EN
  assign bif.err      = err_q;
`endif

endmodule
